// File: rtl/nfsr_pkg.sv
// Shared FSM encoding and default geometry for the NFSR keystream generator.
package nfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } nfsr_state_e;

    localparam int NFSR_WIDTH  = 24;
    localparam int NFSR_OUT_W  = 8;
    localparam int NFSR_WARMUP = 48;
    localparam int NFSR_T1     = 7;
    localparam int NFSR_T2     = 13;
    localparam int NFSR_T3     = 19;

endpackage

// File: rtl/nfsr_core.sv
// NFSR state register: seed load (zero seed remapped to 1) and right shift
// with nonlinear feedback fb = s[0] ^ s[T1] ^ (s[T2] & s[T3]).
module nfsr_core
    import nfsr_pkg::*;
#(
    parameter int WIDTH = NFSR_WIDTH,
    parameter int T1    = NFSR_T1,
    parameter int T2    = NFSR_T2,
    parameter int T3    = NFSR_T3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_shift,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;

    assign w_fb    = r_state[0] ^ r_state[T1] ^ (r_state[T2] & r_state[T3]);
    assign o_state = r_state;

    // Load has priority over shift; an all-zero seed would lock the register, so it becomes 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? WIDTH'(1) : i_seed;
        end else if (i_shift) begin
            r_state <= {w_fb, r_state[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/nfsr_keystream_gen.sv
// Keystream generator: warm-up sequencing, bit collection into OUT_W-bit
// words and a valid/ready output handshake around the NFSR core.
module nfsr_keystream_gen
    import nfsr_pkg::*;
#(
    parameter int WIDTH  = NFSR_WIDTH,
    parameter int OUT_W  = NFSR_OUT_W,
    parameter int WARMUP = NFSR_WARMUP,
    parameter int T1     = NFSR_T1,
    parameter int T2     = NFSR_T2,
    parameter int T3     = NFSR_T3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] Seed,
    input  logic             run_en,
    input  logic             ks_ready,
    output logic [OUT_W-1:0] ks_word,
    output logic             ks_valid,
    output logic [WIDTH-1:0] Par_out,
    output logic             Ser_out,
    output logic             busy
);

    localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
    localparam int BC_W = $clog2(OUT_W);
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(OUT_W - 1);

    nfsr_state_e      r_fsm;
    logic [WC_W-1:0]  r_warm_cnt;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [OUT_W-2:0] r_coll;
    logic [OUT_W-1:0] r_ks_word;
    logic             r_ks_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_state;
    logic             w_ser;
    logic             w_stall;
    logic             w_shift;
    logic [OUT_W-1:0] w_coll_nxt;

    assign w_ser = w_state[0];

    // Holding the last bit back keeps a completed-but-unconsumed word from being overwritten.
    assign w_stall = (r_bit_cnt == BIT_LAST) && r_ks_valid && !ks_ready;
    assign w_shift = !seed_load && run_en &&
                     ((r_fsm == ST_WARMUP) || ((r_fsm == ST_RUN) && !w_stall));

    // Bits enter at the top, so the first captured bit ends up at the word LSB.
    assign w_coll_nxt = {w_ser, r_coll};

    nfsr_core #(
        .WIDTH (WIDTH),
        .T1    (T1),
        .T2    (T2),
        .T3    (T3)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_load  (seed_load),
        .i_seed  (Seed),
        .i_shift (w_shift),
        .o_state (w_state)
    );

    // FSM, warm-up/bit counters, collector and output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm      <= ST_IDLE;
            r_warm_cnt <= '0;
            r_bit_cnt  <= '0;
            r_coll     <= '0;
            r_ks_word  <= '0;
            r_ks_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else if (seed_load) begin
            r_warm_cnt <= '0;
            r_bit_cnt  <= '0;
            r_coll     <= '0;
            r_ks_valid <= 1'b0;
            r_fsm      <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            r_busy     <= (WARMUP != 0);
        end else begin
            // A consumed word drops valid unless a new word lands on the same edge below.
            if (r_ks_valid && ks_ready) begin
                r_ks_valid <= 1'b0;
            end
            case (r_fsm)
                ST_IDLE: begin
                end
                ST_WARMUP: begin
                    if (w_shift) begin
                        if (r_warm_cnt == WARM_LAST) begin
                            r_fsm      <= ST_RUN;
                            r_busy     <= 1'b0;
                            r_warm_cnt <= '0;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_shift) begin
                        r_coll <= w_coll_nxt[OUT_W-1:1];
                        if (r_bit_cnt == BIT_LAST) begin
                            r_ks_word  <= w_coll_nxt;
                            r_ks_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_fsm  <= ST_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign ks_word  = r_ks_word;
    assign ks_valid = r_ks_valid;
    assign Par_out  = w_state;
    assign Ser_out  = w_ser;
    assign busy     = r_busy;

endmodule
